game_sequencer: RTL and testbench

Frame-rate game controller for Pong. It sequences the ball/paddle datapath through attract, serve, play, miss and game-over phases, keeps score and lives, and raises ball speed as rallies lengthen. It sits beside the game datapath: it consumes that datapath's end-of-frame, paddle-hit and miss pulses, and drives the datapath's run/recenter/speed controls and the miss-flash colouring.

---
 rtl/pong_pkg.sv | 36 +++
 rtl/button_sync.sv | 28 ++
 rtl/game_sequencer.sv | 147 ++++++++++++++
 tb/tb_game_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: state encodings, field widths and BCD helpers.
package pong_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SPEED_W = 3;
    localparam int unsigned LIVES_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Two-digit BCD increment that holds at 99.
    function automatic logic [SCORE_W-1:0] bcd_inc_sat(input logic [SCORE_W-1:0] s);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = s[SCORE_W-1:DIGIT_W];
        ones = s[DIGIT_W-1:0];
        if (s == SCORE_W'(8'h99)) begin
            return s;
        end
        if (ones == DIGIT_W'(9)) begin
            ones = '0;
            tens = tens + DIGIT_W'(1);
        end else begin
            ones = ones + DIGIT_W'(1);
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for an asynchronous button plus a rising-edge pulse.
module button_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Combinational so the consuming FSM reacts on the third edge the button is high.
    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Pong game controller: phase sequencing, BCD score, lives and rally-driven ball speed.
module game_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned SERVE_FRAMES   = 60,
    parameter int unsigned MISS_FRAMES    = 63,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned MAX_SPEED      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               hit,
    input  logic               miss,
    output logic               ball_run,
    output logic               ball_center,
    output logic [SPEED_W-1:0] speed,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               flash,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam int unsigned HIT_W      = $clog2(HITS_PER_LEVEL + 1);

    logic start_rise;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               ball_run_q, ball_run_d;
    logic               ball_center_q, ball_center_d;
    logic               flash_q, flash_d;

    button_sync u_start_sync (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (start_btn),
        .rise_c (start_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            hit_cnt_q     <= '0;
            speed_q       <= SPEED_W'(1);
            score_q       <= '0;
            lives_q       <= LIVES_W'(LIVES);
            ball_run_q    <= 1'b0;
            ball_center_q <= 1'b0;
            flash_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hit_cnt_q     <= hit_cnt_d;
            speed_q       <= speed_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            ball_run_q    <= ball_run_d;
            ball_center_q <= ball_center_d;
            flash_q       <= flash_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hit_cnt_d     = hit_cnt_q;
        speed_d       = speed_q;
        score_d       = score_q;
        lives_d       = lives_q;
        ball_center_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d       = ST_SERVE;
                    cnt_d         = CNT_W'(SERVE_FRAMES);
                    hit_cnt_d     = '0;
                    speed_d       = SPEED_W'(1);
                    score_d       = '0;
                    lives_d       = LIVES_W'(LIVES);
                    ball_center_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                // A miss in the same cycle as a hit discards the hit.
                if (miss) begin
                    lives_d = lives_q - LIVES_W'(1);
                    cnt_d   = CNT_W'(MISS_FRAMES);
                    state_d = (lives_q == LIVES_W'(1)) ? ST_OVER : ST_MISS;
                end else if (hit) begin
                    score_d = bcd_inc_sat(score_q);
                    if (hit_cnt_q == HIT_W'(HITS_PER_LEVEL - 1)) begin
                        hit_cnt_d = '0;
                        if (speed_q != SPEED_W'(MAX_SPEED)) begin
                            speed_d = speed_q + SPEED_W'(1);
                        end
                    end else begin
                        hit_cnt_d = hit_cnt_q + HIT_W'(1);
                    end
                end
            end
            ST_MISS: begin
                if (frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d       = ST_SERVE;
                        cnt_d         = CNT_W'(SERVE_FRAMES);
                        ball_center_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ball_run_d = (state_d == ST_PLAY);
        flash_d    = (state_d == ST_MISS);
    end

    assign ball_run    = ball_run_q;
    assign ball_center = ball_center_q;
    assign speed       = speed_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign flash       = flash_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: table-driven PLAY vectors plus multi-cycle phase sequences.
module tb_game_sequencer;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start_btn;
    logic       hit;
    logic       miss;
    logic       ball_run;
    logic       ball_center;
    logic [2:0] speed;
    logic [7:0] score;
    logic [1:0] lives;
    logic       flash;
    logic [2:0] state;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_MISS  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    int checks;
    int failures;

    typedef struct packed {
        logic       hit;
        logic       miss;
        logic       ft;
        logic [7:0] score;
        logic [2:0] speed;
    } vec_t;

    vec_t vecs[22];

    game_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .hit         (hit),
        .miss        (miss),
        .ball_run    (ball_run),
        .ball_center (ball_center),
        .speed       (speed),
        .score       (score),
        .lives       (lives),
        .flash       (flash),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic run,
                             input logic bc, input logic [2:0] spd, input logic [7:0] sc,
                             input logic [1:0] lv, input logic fl);
        check({tag, ".state"},       32'(state),       32'(st));
        check({tag, ".ball_run"},    32'(ball_run),    32'(run));
        check({tag, ".ball_center"}, 32'(ball_center), 32'(bc));
        check({tag, ".speed"},       32'(speed),       32'(spd));
        check({tag, ".score"},       32'(score),       32'(sc));
        check({tag, ".lives"},       32'(lives),       32'(lv));
        check({tag, ".flash"},       32'(flash),       32'(fl));
    endtask

    task automatic pulse(input logic h, input logic m, input logic f);
        hit = h; miss = m; frame_tick = f;
        step();
        hit = 1'b0; miss = 1'b0; frame_tick = 1'b0;
    endtask

    // Idle cycle then a tick cycle; outputs afterwards reflect the final tick edge.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            pulse(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        step();
        check("start_edge1.state", 32'(state), 32'(S_IDLE == state ? state : S_OVER));
        step();
        step();
        start_btn = 1'b0;
    endtask

    function automatic vec_t mk(input logic h, input logic m, input logic f,
                                input logic [7:0] sc, input logic [2:0] sp);
        vec_t v;
        v.hit = h; v.miss = m; v.ft = f; v.score = sc; v.speed = sp;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; frame_tick = 1'b0; start_btn = 1'b0; hit = 1'b0; miss = 1'b0;

        vecs[0]  = mk(1, 0, 0, 8'h01, 3'd1);
        vecs[1]  = mk(1, 0, 0, 8'h02, 3'd1);
        vecs[2]  = mk(1, 0, 0, 8'h03, 3'd1);
        vecs[3]  = mk(1, 0, 1, 8'h04, 3'd2);
        vecs[4]  = mk(0, 0, 1, 8'h04, 3'd2);
        vecs[5]  = mk(0, 0, 0, 8'h04, 3'd2);
        vecs[6]  = mk(1, 0, 0, 8'h05, 3'd2);
        vecs[7]  = mk(1, 0, 0, 8'h06, 3'd2);
        vecs[8]  = mk(1, 0, 0, 8'h07, 3'd2);
        vecs[9]  = mk(1, 0, 0, 8'h08, 3'd3);
        vecs[10] = mk(1, 0, 0, 8'h09, 3'd3);
        vecs[11] = mk(1, 0, 0, 8'h10, 3'd3);
        vecs[12] = mk(1, 0, 0, 8'h11, 3'd3);
        vecs[13] = mk(1, 0, 0, 8'h12, 3'd4);
        vecs[14] = mk(1, 0, 0, 8'h13, 3'd4);
        vecs[15] = mk(1, 0, 0, 8'h14, 3'd4);
        vecs[16] = mk(1, 0, 0, 8'h15, 3'd4);
        vecs[17] = mk(1, 0, 0, 8'h16, 3'd4);
        vecs[18] = mk(1, 0, 0, 8'h17, 3'd4);
        vecs[19] = mk(1, 0, 0, 8'h18, 3'd4);
        vecs[20] = mk(1, 0, 0, 8'h19, 3'd4);
        vecs[21] = mk(1, 0, 0, 8'h20, 3'd4);

        repeat (3) step();
        check_all("reset", S_IDLE, 0, 0, 3'd1, 8'h00, 2'd3, 0);
        reset = 1'b0;

        // Start latency: SERVE on the third edge with the button high.
        start_btn = 1'b1;
        step();
        check("start_e1.state", 32'(state), 32'(S_IDLE));
        step();
        check("start_e2.state", 32'(state), 32'(S_IDLE));
        step();
        check_all("start_e3", S_SERVE, 0, 1, 3'd1, 8'h00, 2'd3, 0);
        step();
        check_all("serve_hold", S_SERVE, 0, 0, 3'd1, 8'h00, 2'd3, 0);
        start_btn = 1'b0;

        frames(59);
        check("serve59.state", 32'(state), 32'(S_SERVE));
        frames(1);
        check_all("play_entry", S_PLAY, 1, 0, 3'd1, 8'h00, 2'd3, 0);

        foreach (vecs[i]) begin
            pulse(vecs[i].hit, vecs[i].miss, vecs[i].ft);
            check_all($sformatf("vec%0d", i), S_PLAY, 1, 0, vecs[i].speed, vecs[i].score, 2'd3, 0);
        end

        // Start edge during PLAY is ignored.
        start_btn = 1'b1;
        repeat (4) step();
        start_btn = 1'b0;
        step();
        check_all("start_in_play", S_PLAY, 1, 0, 3'd4, 8'h20, 2'd3, 0);

        // hit+miss together: miss wins, hit discarded.
        pulse(1, 1, 0);
        check_all("hitmiss_l3", S_MISS, 0, 0, 3'd4, 8'h20, 2'd2, 1);
        pulse(1, 0, 0);
        check("hit_in_miss.score", 32'(score), 32'(8'h20));
        frames(62);
        check_all("miss62", S_MISS, 0, 0, 3'd4, 8'h20, 2'd2, 1);
        frames(1);
        check_all("miss_to_serve", S_SERVE, 0, 1, 3'd4, 8'h20, 2'd2, 0);
        step();
        check("serve_bc_pulse", 32'(ball_center), 32'(0));
        frames(60);
        check_all("replay", S_PLAY, 1, 0, 3'd4, 8'h20, 2'd2, 0);

        pulse(0, 1, 0);
        check_all("miss_l2", S_MISS, 0, 0, 3'd4, 8'h20, 2'd1, 1);
        frames(63);
        check("miss2_serve.state", 32'(state), 32'(S_SERVE));
        frames(60);
        check_all("replay2", S_PLAY, 1, 0, 3'd4, 8'h20, 2'd1, 0);

        pulse(1, 1, 0);
        check_all("game_over", S_OVER, 0, 0, 3'd4, 8'h20, 2'd0, 0);
        pulse(1, 0, 1);
        pulse(0, 1, 0);
        check_all("over_hold", S_OVER, 0, 0, 3'd4, 8'h20, 2'd0, 0);

        start_btn = 1'b1;
        step();
        step();
        check("over_e2.state", 32'(state), 32'(S_OVER));
        step();
        start_btn = 1'b0;
        check_all("restart", S_SERVE, 0, 1, 3'd1, 8'h00, 2'd3, 0);
        frames(60);
        check("restart_play.state", 32'(state), 32'(S_PLAY));

        for (int n = 1; n <= 99; n++) begin
            pulse(1, 0, 0);
            check($sformatf("sat_score%0d", n), 32'(score), 32'(to_bcd(n)));
        end
        pulse(1, 0, 0);
        check_all("score_sat", S_PLAY, 1, 0, 3'd4, 8'h99, 2'd3, 0);

        // Reset mid-countdown in MISS.
        pulse(0, 1, 0);
        check("pre_reset.flash", 32'(flash), 32'(1));
        frames(10);
        reset = 1'b1;
        step();
        check_all("mid_reset", S_IDLE, 0, 0, 3'd1, 8'h00, 2'd3, 0);
        reset = 1'b0;
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        step();
        check_all("idle_ignore", S_IDLE, 0, 0, 3'd1, 8'h00, 2'd3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
